// File: rtl/sram_pkg.sv
// Shared constants and types for the sram data array.
package sram_pkg;

  localparam int unsigned LOG_DEPTH = 7;
  localparam int unsigned BIT_WIDTH = 512;
  localparam int unsigned WORD_SIZE = 64;

  // Number of independently enabled words in one line
  function automatic int unsigned nwords(input int unsigned bit_width,
                                         input int unsigned word_size);
    return bit_width / word_size;
  endfunction

  localparam int unsigned NWORDS = nwords(BIT_WIDTH, WORD_SIZE);

  typedef logic [BIT_WIDTH-1:0] line_t;
  typedef logic [NWORDS-1:0]    wen_t;

endpackage

// File: rtl/sram_word_bank.sv
// One word-wide slice of the sram array: own write enable, registered read.
// Optional feature macro: SRAM_WRITE_FORWARD_EN (write-first bypass on address match).
module sram_word_bank #(
  parameter int unsigned LOGD = 7,
  parameter int unsigned WS   = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [LOGD-1:0] read_addr,
  output logic [WS-1:0]   read_data,
  input  logic [LOGD-1:0] write_addr,
  input  logic [WS-1:0]   write_data,
  input  logic            write_en
);

  localparam int unsigned DEPTH = 2 ** LOGD;

  logic [WS-1:0] mem [DEPTH];

  // Array write; contents survive reset, writes during reset are dropped
  always_ff @(posedge clk) begin
    if (rst_n && write_en) begin
      mem[write_addr] <= write_data;
    end
  end

  // Registered read port, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data <= '0;
    end else begin
`ifdef SRAM_WRITE_FORWARD_EN
      if (write_en && (write_addr == read_addr)) begin
        read_data <= write_data;
      end else begin
        read_data <= mem[read_addr];
      end
`else
      read_data <= mem[read_addr];
`endif
    end
  end

endmodule

// File: rtl/sram.sv
// Simple dual-port synchronous SRAM (one read, one write port) with per-word write mask.
// Optional feature macro: SRAM_WRITE_FORWARD_EN (write-first bypass instead of read-first).
module sram
  import sram_pkg::*;
#(
  parameter int unsigned logDepth = LOG_DEPTH,
  parameter int unsigned bitWidth = BIT_WIDTH,
  parameter int unsigned wordsize = WORD_SIZE
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [logDepth-1:0]                  readAddr,
  output logic [bitWidth-1:0]                  readData,
  input  logic [logDepth-1:0]                  writeAddr,
  input  logic [bitWidth-1:0]                  writeData,
  input  logic [nwords(bitWidth, wordsize)-1:0] writeEnable
);

  localparam int unsigned NW = nwords(bitWidth, wordsize);

  // One bank per write-enable word; outputs concatenate into the line
  for (genvar w = 0; w < NW; w++) begin : g_bank
    sram_word_bank #(
      .LOGD (logDepth),
      .WS   (wordsize)
    ) u_bank (
      .clk        (clk),
      .rst_n      (reset_n),
      .read_addr  (readAddr),
      .read_data  (readData[w*wordsize +: wordsize]),
      .write_addr (writeAddr),
      .write_data (writeData[w*wordsize +: wordsize]),
      .write_en   (writeEnable[w])
    );
  end

endmodule

// File: tb/tb_sram.sv
// Self-checking bench for sram against a line-array reference model.
module tb_sram;
  import sram_pkg::*;

  localparam int unsigned DEPTH = 2 ** LOG_DEPTH;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [LOG_DEPTH-1:0] readAddr;
  line_t                readData;
  logic [LOG_DEPTH-1:0] writeAddr;
  line_t                writeData;
  wen_t                 writeEnable;

  line_t model [DEPTH];
  bit    known [DEPTH];
  int    vectors = 0;
  int    errors  = 0;

  sram dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .readAddr    (readAddr),
    .readData    (readData),
    .writeAddr   (writeAddr),
    .writeData   (writeData),
    .writeEnable (writeEnable)
  );

  always #5 clk = ~clk;

  function automatic line_t rand_line();
    line_t l;
    for (int i = 0; i < BIT_WIDTH / 32; i++) l[i*32 +: 32] = 32'($urandom);
    return l;
  endfunction

  task automatic check(input string tag, input line_t exp);
    vectors++;
    assert (readData === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, readData, exp);
    end
  endtask

  // One clock: drive at negedge, predict from model, update model, check after edge
  task automatic cyc(input logic [LOG_DEPTH-1:0] ra, input logic [LOG_DEPTH-1:0] wa,
                     input line_t wd, input wen_t we, input string tag);
    line_t exp;
    bit    chk;
    @(negedge clk);
    readAddr = ra; writeAddr = wa; writeData = wd; writeEnable = we;
    exp = model[ra];
    chk = known[ra];
`ifdef SRAM_WRITE_FORWARD_EN
    if (ra == wa) begin
      for (int w = 0; w < NWORDS; w++)
        if (we[w]) exp[w*WORD_SIZE +: WORD_SIZE] = wd[w*WORD_SIZE +: WORD_SIZE];
      if (we == '1) chk = 1'b1;
    end
`endif
    @(posedge clk);
    for (int w = 0; w < NWORDS; w++)
      if (we[w]) model[wa][w*WORD_SIZE +: WORD_SIZE] = wd[w*WORD_SIZE +: WORD_SIZE];
    if (we == '1) known[wa] = 1'b1;
    #1;
    if (chk) check(tag, exp);
  endtask

  initial begin
    line_t a, b, x1, x2, pat0, pat127;
    line_t zero = '0;
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    readAddr = '0; writeAddr = '0; writeData = '0; writeEnable = '0;

    // 1. async reset
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1 check("reset_async", zero);
    @(posedge clk); #1 check("reset_held", zero);
    @(negedge clk) reset_n = 1'b1;

    a = rand_line();
    cyc(7'd0, 7'd5, a, 8'hFF, "w5");
    cyc(7'd5, 7'd0, zero, 8'h00, "r5");

    // 2. full line write/read
    cyc(7'd0, 7'd3, {8{64'hDEADBEEF_0000_0003}}, 8'hFF, "w3");
    cyc(7'd3, 7'd0, zero, 8'h00, "r3_full");

    // 3. masked write
    a = rand_line(); b = rand_line();
    cyc(7'd0, 7'd3, a, 8'hFF, "w3_a");
    cyc(7'd0, 7'd3, b, 8'h0F, "w3_b_masked");
    cyc(7'd3, 7'd0, zero, 8'h00, "r3_masked");
    check("r3_masked_mix", {a[511:256], b[255:0]});

    // 4. boundaries and wen=0
    pat0 = {8{64'h0000_0000_AAAA_0000}};
    pat127 = {8{64'h7F7F_7F7F_5555_FFFF}};
    cyc(7'd0, 7'd0, pat0, 8'hFF, "w0");
    cyc(7'd0, 7'd127, pat127, 8'hFF, "w127_r0");
    cyc(7'd127, 7'd0, rand_line(), 8'h00, "r127_wen0");
    cyc(7'd0, 7'd127, rand_line(), 8'h00, "r0_wen0");
    check("r0_literal", pat0);
    cyc(7'd127, 7'd0, zero, 8'h00, "r127_again");
    check("r127_literal", pat127);

    // 5. same-address collision
    x1 = rand_line(); x2 = rand_line();
    cyc(7'd0, 7'd9, x1, 8'hFF, "w9_x1");
    cyc(7'd9, 7'd9, x2, 8'hFF, "collide9");
`ifdef SRAM_WRITE_FORWARD_EN
    check("collide9_fwd", x2);
`else
    check("collide9_rdfirst", x1);
`endif
    cyc(7'd9, 7'd0, zero, 8'h00, "r9_after");
    check("r9_x2", x2);

    // fill the whole array, then randomized traffic
    for (int i = 0; i < DEPTH; i++)
      cyc(7'($urandom_range(0, DEPTH-1)), 7'(i), rand_line(), 8'hFF, "fill");
    for (int i = 0; i < 400; i++) begin
      wen_t we;
      logic [LOG_DEPTH-1:0] ra, wa;
      we = 8'($urandom);
      if (i % 7 == 0) we = '0;
      if (i % 11 == 0) we = '1;
      ra = 7'($urandom_range(0, DEPTH-1));
      wa = (i % 5 == 0) ? ra : 7'($urandom_range(0, DEPTH-1));
      cyc(ra, wa, rand_line(), we, "rand");
    end

    // 6. reset mid-stream; write during reset is ignored
    cyc(7'd20, 7'd0, zero, 8'h00, "stream0");
    cyc(7'd21, 7'd0, zero, 8'h00, "stream1");
    readAddr = 7'd22;
    @(posedge clk); #2 reset_n = 1'b0;
    #1 check("reset_mid", zero);
    @(negedge clk);
    readAddr = 7'd40; writeAddr = 7'd40; writeData = ~model[40]; writeEnable = 8'hFF;
    @(posedge clk); #1 check("reset_mid_held", zero);
    @(negedge clk);
    writeEnable = '0;
    reset_n = 1'b1;
    cyc(7'd40, 7'd0, zero, 8'h00, "r40_after_reset");
    cyc(7'd5, 7'd0, zero, 8'h00, "r5_after_reset");
    cyc(7'd127, 7'd0, zero, 8'h00, "r127_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
